// File: rtl/fetch_buffer_stage.sv
// fetch_buffer_stage
//   Pipelined instruction-fetch stage. It generates PCs and issues in-order
//   imem requests, with up to MAX_OUTSTANDING accesses in flight. Responses
//   are buffered in a DEPTH-entry queue, which feeds Decode over a
//   valid/ready handshake. An Execute redirect (PCSrcE) flushes the queue and
//   discards every response still owed for wrong-path requests.
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   PCSrcE, PCTargetE          redirect request and target from Execute
//   imem_req, imem_addr        fetch request and address (= PC)
//   imem_gnt                   request accepted when imem_req & imem_gnt
//   imem_rvalid, imem_rdata    in-order instruction response
//   valid_D, ready_D           Decode handshake
//   InsD, PC_D, PC_4D          queue head: instruction, its PC, PC + 4
module fetch_buffer_stage #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           DEPTH           = 4,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCSrcE,
  input  logic [ADDR_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  valid_D,
  input  logic                  ready_D,
  output logic [DATA_WIDTH-1:0] InsD,
  output logic [ADDR_WIDTH-1:0] PC_D,
  output logic [ADDR_WIDTH-1:0] PC_4D
);

  localparam int unsigned QAW    = $clog2(DEPTH);
  localparam int unsigned QCW    = $clog2(DEPTH + 1);
  localparam int unsigned OAW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW     = ((QCW > OCW) ? QCW : OCW) + 1;
  localparam int unsigned OSLOTS = 1 << OAW;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] af_addr_q [OSLOTS];
  logic [OAW-1:0]        af_wr_q, af_rd_q;
  logic [OCW-1:0]        inflight_q, inflight_d;
  logic [OCW-1:0]        discard_q, discard_d;
  logic [DATA_WIDTH-1:0] q_ins_q [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_q  [DEPTH];
  logic [QAW-1:0]        q_wr_q, q_rd_q;
  logic [QCW-1:0]        count_q, count_d;

  logic [SW-1:0] credit_use;
  logic          issue, rsp, rsp_keep, pop;

  always_comb begin
    // Queued entries plus owed responses may never exceed DEPTH, so every
    // response always has a queue slot waiting for it.
    credit_use = SW'(count_q) + SW'(inflight_q);
    imem_req   = rst_n & ~PCSrcE & (inflight_q < OCW'(MAX_OUTSTANDING)) &
                 (credit_use < SW'(DEPTH));
    imem_addr  = pc_q;
    issue      = imem_req & imem_gnt;
    rsp        = imem_rvalid & (inflight_q != '0);
    rsp_keep   = rsp & ~PCSrcE & (discard_q == '0);
    valid_D    = (count_q != '0);
    pop        = valid_D & ready_D & ~PCSrcE;

    InsD  = valid_D ? q_ins_q[q_rd_q] : '0;
    PC_D  = valid_D ? q_pc_q[q_rd_q] : '0;
    PC_4D = valid_D ? (q_pc_q[q_rd_q] + ADDR_WIDTH'(4)) : '0;

    pc_d = pc_q;
    if (PCSrcE) begin
      pc_d = PCTargetE;
    end else if (issue) begin
      pc_d = pc_q + ADDR_WIDTH'(4);
    end

    inflight_d = inflight_q + OCW'(issue) - OCW'(rsp);

    // On redirect every response still owed after this cycle is wrong-path;
    // no request is issued in a redirect cycle, so that is inflight minus
    // the response consumed now.
    discard_d = discard_q;
    if (PCSrcE) begin
      discard_d = inflight_q - OCW'(rsp);
    end else if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - OCW'(1);
    end

    count_d = PCSrcE ? '0 : (count_q + QCW'(rsp_keep) - QCW'(pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      af_wr_q    <= '0;
      af_rd_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < OSLOTS; i++) af_addr_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_ins_q[i] <= '0;
        q_pc_q[i]  <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      if (issue) begin
        af_addr_q[af_wr_q] <= pc_q;
        af_wr_q            <= af_wr_q + OAW'(1);
      end
      if (rsp) af_rd_q <= af_rd_q + OAW'(1);
      if (PCSrcE) begin
        q_wr_q <= '0;
        q_rd_q <= '0;
      end else begin
        if (rsp_keep) begin
          q_ins_q[q_wr_q] <= imem_rdata;
          q_pc_q[q_wr_q]  <= af_addr_q[af_rd_q];
          q_wr_q          <= q_wr_q + QAW'(1);
        end
        if (pop) q_rd_q <= q_rd_q + QAW'(1);
      end
    end
  end

  // A response with nothing outstanding is ignored by the logic above.
  a_rvalid_owed: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_buffer_stage.sv
module tb_fetch_buffer_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        valid_D;
  logic        ready_D = 1'b1;
  logic [31:0] InsD, PC_D, PC_4D;

  always #5 clk = ~clk;

  fetch_buffer_stage #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_D(valid_D), .ready_D(ready_D), .InsD(InsD), .PC_D(PC_D), .PC_4D(PC_4D)
  );

  int nvec = 0;
  int nerr = 0;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] memword(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of owed fetches (tagged wrong-path on redirect) and
  // a list of delivered instructions waiting for Decode.
  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
  infl_t       infl[$];
  ent_t        fq[$];
  logic [31:0] m_pc = '0;

  // Simple imem: accepted addresses answered in order, one per cycle.
  logic [31:0] pend[$];
  bit          resp_en = 1'b1;
  bit          bus_acc = 1'b0;
  logic [31:0] bus_addr = '0;

  task automatic model_reset();
    infl.delete();
    fq.delete();
    m_pc = '0;
  endtask

  task automatic model_step();
    bit    m_req;
    bit    do_pop;
    infl_t e;
    m_req  = !PCSrcE && (infl.size() < 2) && ((fq.size() + infl.size()) < 4);
    do_pop = !PCSrcE && (fq.size() != 0) && ready_D;
    if (imem_rvalid && infl.size() != 0) begin
      e = infl.pop_front();
      if (!e.stale && !PCSrcE) fq.push_back('{memword(e.pc), e.pc});
    end
    if (do_pop) void'(fq.pop_front());
    if (m_req && imem_gnt) begin
      infl.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (PCSrcE) begin
      m_pc = PCTargetE;
      fq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      pend.delete();
    end else begin
      model_step();
      if (imem_rvalid) void'(pend.pop_front());
      if (bus_acc) pend.push_back(bus_addr);
    end
    #1;
    imem_rvalid = rst_n && resp_en && (pend.size() != 0);
    imem_rdata  = imem_rvalid ? memword(pend[0]) : '0;
  endtask

  always @(negedge clk) begin : cmp
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_ins, e_pc, e_pc4;
    e_req = 1'b0; e_valid = 1'b0; e_addr = '0; e_ins = '0; e_pc = '0; e_pc4 = '0;
    if (rst_n) begin
      e_req   = !PCSrcE && (infl.size() < 2) && ((fq.size() + infl.size()) < 4);
      e_addr  = m_pc;
      e_valid = (fq.size() != 0);
      if (e_valid) begin
        e_ins = fq[0].ins;
        e_pc  = fq[0].pc;
        e_pc4 = fq[0].pc + 32'd4;
      end
    end
    chk("imem_req",  {31'b0, imem_req}, {31'b0, e_req});
    chk("imem_addr", imem_addr, e_addr);
    chk("valid_D",   {31'b0, valid_D}, {31'b0, e_valid});
    chk("InsD",      InsD, e_ins);
    chk("PC_D",      PC_D, e_pc);
    chk("PC_4D",     PC_4D, e_pc4);
    bus_acc  = imem_req & imem_gnt;
    bus_addr = imem_addr;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    model_reset();
    pend.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(string nm, int lim);
    bit found;
    found = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (valid_D) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    nvec++;
    if (!found) begin
      nerr++;
      $display("FAIL %s: valid_D never rose within %0d cycles", nm, lim);
    end
  endtask

  logic [31:0] rp, gp, ep;

  initial begin
    // Reset state and steady streaming after a 2-cycle fill
    do_reset();
    tick();
    tick();
    @(negedge clk);
    chk("t1_valid", {31'b0, valid_D}, 32'd1);
    chk("t1_pc0",   PC_D, 32'h0);
    chk("t1_pc4d0", PC_4D, 32'h4);
    tick(); @(negedge clk); chk("t1_pc1", PC_D, 32'h4);
    tick(); @(negedge clk); chk("t1_pc2", PC_D, 32'h8);
    repeat (4) tick();

    // Back-pressure: queue fills to DEPTH, issue halts, then drains in order
    ready_D = 1'b0;
    do_reset();
    repeat (10) tick();
    @(negedge clk);
    chk("t2_req_halt", {31'b0, imem_req}, 32'd0);
    chk("t2_addr",     imem_addr, 32'h10);
    chk("t2_head",     PC_D, 32'h0);
    ready_D = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_pop1",   PC_D, 32'h4);
    chk("t2_resume", {31'b0, imem_req}, 32'd1);
    chk("t2_raddr",  imem_addr, 32'h10);
    repeat (6) tick();

    // Redirect with two requests in flight
    resp_en = 1'b0;
    do_reset();
    tick();
    tick();
    @(negedge clk);
    chk("t3_credit_stop", {31'b0, imem_req}, 32'd0);
    PCSrcE = 1'b1; PCTargetE = 32'h100; resp_en = 1'b1;
    tick();
    PCSrcE = 1'b0;
    wait_valid("t3_wait", 20);
    chk("t3_pc",  PC_D, 32'h100);
    chk("t3_pc4", PC_4D, 32'h104);
    chk("t3_ins", InsD, memword(32'h100));

    // Redirect coinciding with a response and a Decode handshake
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h200;
    @(negedge clk);
    chk("t4_head_before", PC_D, 32'h104);
    tick();
    PCSrcE = 1'b0;
    wait_valid("t4_wait", 20);
    chk("t4_pc",  PC_D, 32'h200);
    chk("t4_pc4", PC_4D, 32'h204);

    // Grant withheld for 3 cycles
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_req_hold",  {31'b0, imem_req}, 32'd1);
      chk("t5_addr_hold", imem_addr, 32'h20C);
      tick();
    end
    imem_gnt = 1'b1;
    repeat (6) tick();

    // Back-to-back redirects: the later target wins
    PCSrcE = 1'b1; PCTargetE = 32'h300;
    tick();
    PCTargetE = 32'h400;
    tick();
    PCSrcE = 1'b0;
    wait_valid("t6_wait", 20);
    chk("t6_pc", PC_D, 32'h400);

    // Address wrap at the top of the address space
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
    tick();
    PCSrcE = 1'b0;
    wait_valid("t7_wait", 20);
    chk("t7_pc_a",  PC_D, 32'hFFFF_FFF8);
    chk("t7_pc4_a", PC_4D, 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    chk("t7_pc_b",  PC_D, 32'hFFFF_FFFC);
    chk("t7_pc4_b", PC_4D, 32'h0);
    tick(); @(negedge clk);
    chk("t7_pc_c",  PC_D, 32'h0);
    chk("t7_pc4_c", PC_4D, 32'h4);

    // Mixed stall pattern on ready, grant and response timing
    rp = 32'hF3B7_6DDF;
    gp = 32'hDB6F_B5EE;
    ep = 32'hEEDB_7BDF;
    for (int i = 0; i < 40; i++) begin
      ready_D  = rp[i % 32];
      imem_gnt = gp[i % 32];
      resp_en  = ep[i % 32];
      PCSrcE   = (i == 17) || (i == 29);
      PCTargetE = (i == 17) ? 32'h1000 : 32'h2000;
      tick();
    end
    PCSrcE = 1'b0; ready_D = 1'b1; imem_gnt = 1'b1; resp_en = 1'b1;
    repeat (10) tick();

    // Asynchronous reset in the middle of streaming
    tick();
    #3;
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    model_reset();
    pend.delete();
    @(negedge clk);
    chk("t9_valid", {31'b0, valid_D}, 32'd0);
    chk("t9_req",   {31'b0, imem_req}, 32'd0);
    chk("t9_pcd",   PC_D, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("t9_restart", PC_D, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
